// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: common data bus broadcast payload.
package store_buffer_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ROB_W  = 3;

    typedef struct packed {
        logic              valid;
        logic [ROB_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_t;

endpackage

// File: rtl/store_buffer_if.sv
// Dcache write port: request with address/data/lane enables, single-bit completion.
interface store_buffer_if #(
    parameter int unsigned data_width = 16
) ();

    logic                  dmem_write;
    logic [data_width-1:0] dmem_addr;
    logic [data_width-1:0] dmem_wdata;
    logic [1:0]            dmem_byte_enable;
    logic                  dmem_resp;

    modport master (
        output dmem_write, dmem_addr, dmem_wdata, dmem_byte_enable,
        input  dmem_resp
    );

    modport slave (
        input  dmem_write, dmem_addr, dmem_wdata, dmem_byte_enable,
        output dmem_resp
    );

endinterface

// File: rtl/store_buffer.sv
// In-order store queue: allocates STR/STB, snoops the CDB for operands, and writes
// committed, resolved stores to the dcache one at a time from the head.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned data_width     = DATA_W,
    parameter int unsigned entries_addr   = 2,
    parameter int unsigned rob_addr_width = ROB_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      WE,
    input  logic                      flush,
    input  logic [rob_addr_width-1:0] Qb_in,
    input  logic [data_width-1:0]     Vb_in,
    input  logic                      Vb_valid_in,
    input  logic [rob_addr_width-1:0] Qs_in,
    input  logic [data_width-1:0]     Vs_in,
    input  logic                      Vs_valid_in,
    input  logic [data_width-1:0]     offset_in,
    input  logic                      byte_in,
    input  logic [rob_addr_width-1:0] dest_in,
    input  cdb_t                      CDB_in,
    input  logic                      commit,
    input  logic [rob_addr_width-1:0] commit_tag,
    store_buffer_if.master            dmem,
    output logic                      empty,
    output logic                      full
);

    localparam int unsigned N     = 1 << entries_addr;
    localparam int unsigned CNT_W = entries_addr + 1;

    typedef struct packed {
        logic                      valid;
        logic                      committed;
        logic [data_width-1:0]     vb;
        logic [rob_addr_width-1:0] qb;
        logic                      rb;
        logic [data_width-1:0]     vs;
        logic [rob_addr_width-1:0] qs;
        logic                      rs;
        logic [data_width-1:0]     offset;
        logic                      is_byte;
        logic [rob_addr_width-1:0] dest;
    } entry_t;

    typedef enum logic {IDLE, WRITE} state_t;

    entry_t                ent_q [N];
    entry_t                ent_d [N];
    logic [entries_addr-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    state_t                state_q, state_d;
    logic                  write_q, write_d;
    logic [data_width-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [1:0]            be_q, be_d;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(N));

    assign dmem.dmem_write       = write_q;
    assign dmem.dmem_addr        = addr_q;
    assign dmem.dmem_wdata       = wdata_q;
    assign dmem.dmem_byte_enable = be_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N); i++) ent_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            for (int i = 0; i < int'(N); i++) ent_q[i] <= ent_d[i];
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    // Update order: snoop, commit, FSM pop, then flush or allocate.
    always_comb begin
        entry_t      head_ent;
        entry_t      new_ent;
        logic        pop;
        logic        alloc;
        int unsigned keep;

        for (int i = 0; i < int'(N); i++) ent_d[i] = ent_q[i];
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        state_d  = state_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        head_ent = ent_q[head_q];
        new_ent  = '0;
        pop      = 1'b0;
        alloc    = 1'b0;
        keep     = 0;

        if (CDB_in.valid) begin
            for (int i = 0; i < int'(N); i++) begin
                if (ent_q[i].valid && !ent_q[i].rb && ent_q[i].qb == CDB_in.tag) begin
                    ent_d[i].vb = CDB_in.data;
                    ent_d[i].rb = 1'b1;
                end
                if (ent_q[i].valid && !ent_q[i].rs && ent_q[i].qs == CDB_in.tag) begin
                    ent_d[i].vs = CDB_in.data;
                    ent_d[i].rs = 1'b1;
                end
            end
        end

        if (commit) begin
            for (int i = 0; i < int'(N); i++) begin
                if (ent_q[i].valid && ent_q[i].dest == commit_tag) ent_d[i].committed = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (head_ent.valid && head_ent.committed && head_ent.rb && head_ent.rs) begin
                    addr_d = head_ent.vb + head_ent.offset;
                    if (head_ent.is_byte) begin
                        wdata_d = {head_ent.vs[7:0], head_ent.vs[7:0]};
                        be_d    = addr_d[0] ? 2'b10 : 2'b01;
                    end else begin
                        wdata_d = head_ent.vs;
                        be_d    = 2'b11;
                    end
                    write_d = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (dmem.dmem_resp) begin
                    ent_d[head_q].valid     = 1'b0;
                    ent_d[head_q].committed = 1'b0;
                    head_d  = head_q + entries_addr'(1);
                    write_d = 1'b0;
                    state_d = IDLE;
                    pop     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            // Committed entries form a prefix from head, so they are all that survive.
            for (int i = 0; i < int'(N); i++) begin
                if (!ent_d[i].committed) ent_d[i].valid = 1'b0;
                else if (ent_d[i].valid) keep++;
            end
            tail_d  = head_d + entries_addr'(keep);
            count_d = CNT_W'(keep);
        end else begin
            if (WE && !full) begin
                alloc           = 1'b1;
                new_ent.valid   = 1'b1;
                new_ent.qb      = Qb_in;
                new_ent.qs      = Qs_in;
                new_ent.offset  = offset_in;
                new_ent.is_byte = byte_in;
                new_ent.dest    = dest_in;
                new_ent.rb      = Vb_valid_in || (CDB_in.valid && CDB_in.tag == Qb_in);
                new_ent.vb      = Vb_valid_in ? Vb_in : CDB_in.data;
                new_ent.rs      = Vs_valid_in || (CDB_in.valid && CDB_in.tag == Qs_in);
                new_ent.vs      = Vs_valid_in ? Vs_in : CDB_in.data;
                ent_d[tail_q]   = new_ent;
                tail_d          = tail_q + entries_addr'(1);
            end
            count_d = count_q - CNT_W'(pop) + CNT_W'(alloc);
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: latency, STB lanes, CDB snoop/bypass, full, flush, reset.
module tb_store_buffer;
    import store_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        WE = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  Qb_in = '0;
    logic [15:0] Vb_in = '0;
    logic        Vb_valid_in = 1'b0;
    logic [2:0]  Qs_in = '0;
    logic [15:0] Vs_in = '0;
    logic        Vs_valid_in = 1'b0;
    logic [15:0] offset_in = '0;
    logic        byte_in = 1'b0;
    logic [2:0]  dest_in = '0;
    cdb_t        cdb = '0;
    logic        commit = 1'b0;
    logic [2:0]  commit_tag = '0;
    logic        empty, full;

    int checks = 0;
    int errors = 0;

    store_buffer_if #(.data_width(16)) dif ();

    store_buffer dut (
        .clk(clk), .rst_n(rst_n), .WE(WE), .flush(flush),
        .Qb_in(Qb_in), .Vb_in(Vb_in), .Vb_valid_in(Vb_valid_in),
        .Qs_in(Qs_in), .Vs_in(Vs_in), .Vs_valid_in(Vs_valid_in),
        .offset_in(offset_in), .byte_in(byte_in), .dest_in(dest_in),
        .CDB_in(cdb), .commit(commit), .commit_tag(commit_tag),
        .dmem(dif.master), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic [2:0] qb, input logic [15:0] vb, input logic vbv,
                         input logic [2:0] qs, input logic [15:0] vs, input logic vsv,
                         input logic [15:0] off, input logic is_byte, input logic [2:0] dest);
        Qb_in = qb; Vb_in = vb; Vb_valid_in = vbv;
        Qs_in = qs; Vs_in = vs; Vs_valid_in = vsv;
        offset_in = off; byte_in = is_byte; dest_in = dest;
        WE = 1'b1;
        step();
        WE = 1'b0; Vb_valid_in = 1'b0; Vs_valid_in = 1'b0;
    endtask

    task automatic do_commit(input logic [2:0] t);
        commit_tag = t;
        commit = 1'b1;
        step();
        commit = 1'b0;
    endtask

    task automatic respond();
        dif.dmem_resp = 1'b1;
        step();
        dif.dmem_resp = 1'b0;
    endtask

    task automatic wait_write(input string tag);
        int n = 0;
        while (!dif.dmem_write && n < 20) begin
            step();
            n++;
        end
        check({tag, "_req"}, 32'(dif.dmem_write), 32'd1);
    endtask

    task automatic expect_write(input string tag, input logic [15:0] addr,
                                input logic [15:0] wdata, input logic [1:0] be);
        check({tag, "_addr"}, 32'(dif.dmem_addr), 32'(addr));
        check({tag, "_wdata"}, 32'(dif.dmem_wdata), 32'(wdata));
        check({tag, "_be"}, 32'(dif.dmem_byte_enable), 32'(be));
    endtask

    initial begin
        dif.dmem_resp = 1'b0;
        #12;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_write", 32'(dif.dmem_write), 32'd0);
        check("rst_addr", 32'(dif.dmem_addr), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // STR, both operands ready; commit at N, request at N+2
        alloc(3'd0, 16'h1000, 1'b1, 3'd0, 16'hBEEF, 1'b1, 16'h0004, 1'b0, 3'd2);
        check("str_nonempty", 32'(empty), 32'd0);
        do_commit(3'd2);
        check("str_n1_write", 32'(dif.dmem_write), 32'd0);
        step();
        check("str_n2_write", 32'(dif.dmem_write), 32'd1);
        expect_write("str", 16'h1004, 16'hBEEF, 2'b11);
        step();
        step();
        check("str_held_write", 32'(dif.dmem_write), 32'd1);
        check("str_held_addr", 32'(dif.dmem_addr), 32'h1004);
        respond();
        check("str_done_write", 32'(dif.dmem_write), 32'd0);
        check("str_done_empty", 32'(empty), 32'd1);

        // STB with store data from CDB tag 5
        alloc(3'd0, 16'h2001, 1'b1, 3'd5, 16'h0000, 1'b0, 16'h0000, 1'b1, 3'd3);
        cdb = '{valid: 1'b1, tag: 3'd5, data: 16'h12AB};
        step();
        cdb = '0;
        do_commit(3'd3);
        check("stb_n1_write", 32'(dif.dmem_write), 32'd0);
        step();
        check("stb_n2_write", 32'(dif.dmem_write), 32'd1);
        expect_write("stb", 16'h2001, 16'hABAB, 2'b10);
        respond();
        check("stb_empty", 32'(empty), 32'd1);

        // Fill to full, extra WE ignored, drain in order across the wrap
        for (int i = 0; i < 4; i++)
            alloc(3'd0, 16'h3000, 1'b1, 3'd0, 16'hA000 + 16'(i), 1'b1, 16'(2 * i), 1'b0, 3'(i));
        check("fill_full", 32'(full), 32'd1);
        alloc(3'd0, 16'h7000, 1'b1, 3'd0, 16'h7777, 1'b1, 16'h0000, 1'b0, 3'd4);
        check("fill_ignored_full", 32'(full), 32'd1);
        check("fill_ignored_nonempty", 32'(empty), 32'd0);
        for (int i = 0; i < 4; i++) do_commit(3'(i));
        for (int i = 0; i < 4; i++) begin
            wait_write($sformatf("drain%0d", i));
            expect_write($sformatf("drain%0d", i), 16'h3000 + 16'(2 * i), 16'hA000 + 16'(i), 2'b11);
            respond();
        end
        check("drain_empty", 32'(empty), 32'd1);
        step();
        step();
        check("drain_no_extra", 32'(dif.dmem_write), 32'd0);

        // Base captured from a same-cycle CDB broadcast
        cdb = '{valid: 1'b1, tag: 3'd3, data: 16'h0040};
        alloc(3'd3, 16'h0000, 1'b0, 3'd0, 16'h5555, 1'b1, 16'h0010, 1'b0, 3'd5);
        cdb = '0;
        do_commit(3'd5);
        step();
        check("byp_write", 32'(dif.dmem_write), 32'd1);
        expect_write("byp", 16'h0050, 16'h5555, 2'b11);
        respond();
        check("byp_empty", 32'(empty), 32'd1);

        // Flush keeps only the committed head, drops a same-cycle WE
        alloc(3'd0, 16'h4000, 1'b1, 3'd0, 16'h0101, 1'b1, 16'h0000, 1'b0, 3'd1);
        alloc(3'd0, 16'h4000, 1'b1, 3'd0, 16'h0202, 1'b1, 16'h0002, 1'b0, 3'd2);
        alloc(3'd0, 16'h4000, 1'b1, 3'd0, 16'h0303, 1'b1, 16'h0004, 1'b0, 3'd3);
        do_commit(3'd1);
        step();
        check("fl_write", 32'(dif.dmem_write), 32'd1);
        flush = 1'b1;
        alloc(3'd0, 16'h6000, 1'b1, 3'd0, 16'h0606, 1'b1, 16'h0000, 1'b0, 3'd6);
        flush = 1'b0;
        check("fl_nonempty", 32'(empty), 32'd0);
        check("fl_write_held", 32'(dif.dmem_write), 32'd1);
        expect_write("fl", 16'h4000, 16'h0101, 2'b11);
        respond();
        check("fl_empty", 32'(empty), 32'd1);
        do_commit(3'd2);
        do_commit(3'd6);
        step();
        step();
        check("fl_no_stale_write", 32'(dif.dmem_write), 32'd0);

        // Async reset in the middle of a write
        for (int i = 0; i < 4; i++)
            alloc(3'd0, 16'h5000, 1'b1, 3'd0, 16'h0F0F, 1'b1, 16'(i), 1'b0, 3'(i));
        do_commit(3'd0);
        do_commit(3'd1);
        check("rw_write", 32'(dif.dmem_write), 32'd1);
        check("rw_full", 32'(full), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rw_write_drop", 32'(dif.dmem_write), 32'd0);
        check("rw_empty", 32'(empty), 32'd1);
        check("rw_full_clr", 32'(full), 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("rw_no_write_after", 32'(dif.dmem_write), 32'd0);
        check("rw_still_empty", 32'(empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
